// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - rv32i types shared by the writeback unit
package rv32i;

    typedef enum logic {
        REG_WE_OFF = 1'b0,
        REG_WE_ON  = 1'b1
    } reg_we_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2
    } wb_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU/load/memory/decode/regfile signals of the writeback unit
interface writeback_unit_if;
    import rv32i::*;

    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        stall;
    reg_we_e     we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        input  mem_rvalid, mem_rdata,
        input  dec_rs1, dec_rs2, dec_rd,
        output ld_ready, stall, we, rd_addr, rd_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        output mem_rvalid, mem_rdata,
        output dec_rs1, dec_rs2, dec_rd,
        input  ld_ready, stall, we, rd_addr, rd_data
    );
endinterface

// File: rtl/writeback_unit_load_extend.sv
// rtl/writeback_unit_load_extend.sv - selects and extends the loaded byte/halfword/word
module load_extend
    import rv32i::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] value
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      value = {{24{byte_sel[7]}}, byte_sel};
            LH:      value = {{16{half_sel[15]}}, half_sel};
            LW:      value = word;
            LBU:     value = {24'd0, byte_sel};
            LHU:     value = {16'd0, half_sel};
            default: value = 32'd0;
        endcase
    end
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU results and one outstanding load into the regfile write port
module writeback_unit
    import rv32i::*;
(
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.slave  bus
);
    wb_state_e   state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] ext_data;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    load_extend u_load_extend (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .word    (bus.mem_rdata),
        .value   (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_q      <= 5'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            hold_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.ld_issue) begin
                    rd_d      = bus.ld_rd;
                    funct3_d  = bus.ld_funct3;
                    addr_lo_d = bus.ld_addr_lo;
                    state_d   = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // A colliding ALU write wins the port; park the load result.
                if (bus.mem_rvalid) begin
                    if (bus.alu_valid) begin
                        hold_d  = ext_data;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!bus.alu_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        if (bus.alu_valid) begin
            wr_en   = 1'b1;
            wr_addr = bus.alu_rd;
            wr_data = bus.alu_data;
        end else if (state_q == WAIT_MEM && bus.mem_rvalid) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = ext_data;
        end else if (state_q == HOLD) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = hold_q;
        end

        bus.we      = REG_WE_OFF;
        bus.rd_addr = 5'd0;
        bus.rd_data = 32'd0;
        // x0 destinations and anything seen while in reset are dropped entirely.
        if (wr_en && wr_addr != 5'd0 && !reset) begin
            bus.we      = REG_WE_ON;
            bus.rd_addr = wr_addr;
            bus.rd_data = wr_data;
        end

        bus.ld_ready = (state_q == IDLE);
        bus.stall    = (state_q != IDLE) && (rd_q != 5'd0) &&
                       (bus.dec_rs1 == rd_q || bus.dec_rs2 == rd_q || bus.dec_rd == rd_q);
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports alu_valid (in, 1), alu_rd (in, 5) and alu_data (in, 32): single-cycle ALU result to write back.
REQ-004 SHALL have ports ld_issue (in, 1), ld_ready (out, 1), ld_rd (in, 5), ld_funct3 (in, 3) and ld_addr_lo (in, 2): load issue handshake.
REQ-005 SHALL have ports mem_rvalid (in, 1) and mem_rdata (in, 32): memory read response, word-aligned data.
REQ-006 SHALL have ports dec_rs1, dec_rs2 and dec_rd (in, 5 each) and stall (out, 1): hazard query from decode.
REQ-007 SHALL have ports we (out, reg_we_e), rd_addr (out, 5) and rd_data (out, 32): register-file write port.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT_MEM and HOLD.
REQ-009 SHALL drive ld_ready = 1 only in IDLE; a load is accepted when ld_issue && ld_ready, which latches ld_rd, ld_funct3 and ld_addr_lo and moves to WAIT_MEM.
REQ-010 SHALL ignore mem_rvalid in IDLE and HOLD.
REQ-011 WAIT_MEM with mem_rvalid && !alu_valid SHALL drive the extended load data onto the write port in the same cycle and return to IDLE.
REQ-012 WAIT_MEM with mem_rvalid && alu_valid SHALL perform the ALU write, capture the extended load data into a hold register and move to HOLD.
REQ-013 HOLD with !alu_valid SHALL write the held data to the latched rd and go to IDLE; HOLD with alu_valid SHALL write the ALU result and stay in HOLD.
REQ-014 ALU writes SHALL always take priority and SHALL never be delayed; latency is 0 cycles, combinational to the write port.
REQ-015 Any write with destination x0 SHALL drive we to the non-write value of reg_we_e.
REQ-016 When no write occurs, we SHALL be non-write, and rd_addr/rd_data SHALL be 0.
REQ-017 Load extension: funct3 000 LB, 100 LBU use byte ld_addr_lo; 001 LH, 101 LHU use halfword ld_addr_lo[1]; 010 LW uses the full word.
REQ-018 Load extension: LB and LH sign-extend; LBU and LHU zero-extend; any other funct3 yields 0.
REQ-019 stall SHALL be 1 when the state is not IDLE, the pending rd is nonzero, and any of dec_rs1, dec_rs2 or dec_rd equals the pending rd; this covers RAW and WAW hazards.
REQ-020 stall SHALL be 0 in IDLE.
REQ-021 ld_issue while ld_ready = 0 SHALL be ignored; the issuer holds the request.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE and clear the latched rd, funct3, addr_lo and hold register.
REQ-023 During reset, outputs SHALL be: we non-write, rd_addr 0, rd_data 0, stall 0, ld_ready 1.
REQ-024 Reset during WAIT_MEM or HOLD SHALL discard the pending load; a later mem_rvalid SHALL produce no write.

Structure
REQ-025 The wb_state_e enum and the load funct3 constants (LB, LH, LW, LBU, LHU) SHALL live in the rv32i package; reg_we_e SHALL be reused from it.
REQ-026 Load extension SHALL be a combinational sub-module named load_extend (inputs: funct3, addr_lo, word; output: 32-bit value).

Verification
REQ-027 Test 1 SHALL issue LW rd=5, then drive mem_rvalid with mem_rdata=0xDEADBEEF and alu_valid=0, and expect the same-cycle write x5=0xDEADBEEF and a return to IDLE.
REQ-028 Test 2 SHALL issue LB rd=3 with addr_lo=2 and mem_rdata=0x00800000, and expect the write x3=0xFFFFFF80; the same access with LBU SHALL expect 0x00000080.
REQ-029 Test 3 SHALL issue LH rd=7 with addr_lo=2, then drive mem_rvalid together with alu_valid (rd=9, data=0x11) for one cycle, then a second ALU write (rd=10, 0x22).
REQ-030 Test 3 SHALL expect x9=0x11, then x10=0x22 while HOLD persists, then x7 written on the first idle cycle.
REQ-031 Test 4 SHALL issue a load with rd=4 and apply dec_rs1=4, dec_rs2=4 and dec_rd=4 each in turn, expecting stall=1; dec_*=0 SHALL expect stall=0; with rd=0 pending, stall SHALL be 0.
REQ-032 Test 5 SHALL assert reset in WAIT_MEM, then drive mem_rvalid, and expect no write, ld_ready=1 and stall=0.
REQ-033 Test 6 SHALL drive alu_valid with rd=0 and data=0x5, expect we non-write, and expect ld_issue while in WAIT_MEM to be ignored (the latched rd is unchanged).
